// File: rtl/clock_mode_ctrl.sv
// Time-of-day counter with RUN / SET_HR / SET_MIN modes, button auto-repeat and set-field blink.
// All outputs registered; events act on the clk edge where the input rising edge is seen.
module clock_mode_ctrl #(
  parameter int RPT_DLY = 500,
  parameter int RPT_PER = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1hz,
  input  logic       clk_out,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_SET_HR  = 2'b01,
    S_SET_MIN = 2'b10,
    S_BAD     = 2'b11
  } state_t;

  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int CW      = $clog2(RPT_MAX + 1);

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_hr, w_hr_nxt;
  logic [5:0]    r_min, w_min_nxt;
  logic [5:0]    r_sec, w_sec_nxt;
  logic          r_blink, w_blink_nxt;
  logic [CW-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
  logic          r_rpt_arm, w_rpt_arm_nxt;
  logic          r_1hz_d, r_out_d, r_mode_d, r_inc_d;

  logic          w_1hz_re, w_out_re, w_mode_re, w_inc_re;
  logic          w_rpt_stb, w_inc_ev;
  logic [CW-1:0] w_rpt_lim;

  assign w_1hz_re  = clk_1hz  & ~r_1hz_d;
  assign w_out_re  = clk_out  & ~r_out_d;
  assign w_mode_re = btn_mode & ~r_mode_d;
  assign w_inc_re  = btn_inc  & ~r_inc_d;
  assign w_rpt_lim = r_rpt_arm ? CW'(RPT_PER) : CW'(RPT_DLY);
  assign w_inc_ev  = w_inc_re | w_rpt_stb;

  always_comb begin
    w_state_nxt   = r_state;
    w_hr_nxt      = r_hr;
    w_min_nxt     = r_min;
    w_sec_nxt     = r_sec;
    w_blink_nxt   = r_blink;
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_rpt_arm_nxt = r_rpt_arm;
    w_rpt_stb     = 1'b0;

    // The strobe fires on the clk_out edge after the count reaches the limit; that edge restarts the count at 1.
    if (!btn_inc || w_mode_re || r_state == S_RUN || r_state == S_BAD) begin
      w_rpt_cnt_nxt = '0;
      w_rpt_arm_nxt = 1'b0;
    end else if (w_out_re) begin
      if (r_rpt_cnt == w_rpt_lim) begin
        w_rpt_stb     = 1'b1;
        w_rpt_cnt_nxt = CW'(1);
        w_rpt_arm_nxt = 1'b1;
      end else begin
        w_rpt_cnt_nxt = r_rpt_cnt + CW'(1);
      end
    end

    case (r_state)
      S_RUN: begin
        w_blink_nxt = 1'b0;
        if (w_1hz_re) begin
          if (r_sec == 6'd59) begin
            w_sec_nxt = 6'd0;
            if (r_min == 6'd59) begin
              w_min_nxt = 6'd0;
              w_hr_nxt  = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
            end else begin
              w_min_nxt = r_min + 6'd1;
            end
          end else begin
            w_sec_nxt = r_sec + 6'd1;
          end
        end
        if (w_mode_re) begin
          w_state_nxt = S_SET_HR;
          w_blink_nxt = 1'b1;
        end
      end
      S_SET_HR: begin
        if (w_mode_re) begin
          w_state_nxt = S_SET_MIN;
          w_blink_nxt = 1'b1;
        end else begin
          if (w_inc_ev) w_hr_nxt = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
          if (w_1hz_re) w_blink_nxt = ~r_blink;
        end
      end
      S_SET_MIN: begin
        if (w_mode_re) begin
          w_state_nxt = S_RUN;
          w_sec_nxt   = 6'd0;
          w_blink_nxt = 1'b0;
        end else begin
          if (w_inc_ev) w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
          if (w_1hz_re) w_blink_nxt = ~r_blink;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_blink_nxt = 1'b0;
      end
    endcase
  end

  // Button history loads 1 in reset so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_RUN;
      r_hr      <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_blink   <= 1'b0;
      r_rpt_cnt <= '0;
      r_rpt_arm <= 1'b0;
      r_1hz_d   <= clk_1hz;
      r_out_d   <= clk_out;
      r_mode_d  <= 1'b1;
      r_inc_d   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_hr      <= w_hr_nxt;
      r_min     <= w_min_nxt;
      r_sec     <= w_sec_nxt;
      r_blink   <= w_blink_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
      r_rpt_arm <= w_rpt_arm_nxt;
      r_1hz_d   <= clk_1hz;
      r_out_d   <= clk_out;
      r_mode_d  <= btn_mode;
      r_inc_d   <= btn_inc;
    end
  end

  assign hr    = r_hr;
  assign min   = r_min;
  assign sec   = r_sec;
  assign mode  = r_state;
  assign blink = r_blink;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: time rollover, mode cycling, set-field wrap, auto-repeat, collisions, reset.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_1hz = 1'b0;
  logic       clk_out = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       blink;

  int n_chk  = 0;
  int n_pass = 0;

  clock_mode_ctrl #(.RPT_DLY(500), .RPT_PER(100)) dut (
    .clk(clk), .reset(reset), .clk_1hz(clk_1hz), .clk_out(clk_out),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr(hr), .min(min), .sec(sec), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; clk_1hz = 1'b0; clk_out = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; cyc(); btn_mode = 1'b0; cyc();
  endtask

  task automatic pulse_inc();
    btn_inc = 1'b1; cyc(); btn_inc = 1'b0; cyc();
  endtask

  task automatic pulse_1hz();
    clk_1hz = 1'b1; cyc(); clk_1hz = 1'b0; cyc();
  endtask

  // Reaches h:m:s in RUN by setting fields then letting seconds run.
  task automatic goto_time(input int h, input int m, input int s);
    do_reset();
    pulse_mode();
    for (int i = 0; i < h; i++) pulse_inc();
    pulse_mode();
    for (int i = 0; i < m; i++) pulse_inc();
    pulse_mode();
    for (int i = 0; i < s; i++) pulse_1hz();
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_1hz = 1'b0; clk_out = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(); cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0})
      $display("FAIL reset_state: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:0:0 mode=0 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_rollover();
    goto_time(23, 59, 58);
    pulse_1hz();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd23, 6'd59, 6'd59, 2'd0, 1'b0})
      $display("FAIL rollover_59: got %0d:%0d:%0d mode=%0d blink=%0d, want 23:59:59 mode=0 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
    pulse_1hz();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0})
      $display("FAIL rollover_midnight: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:0:0 mode=0 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
  endtask

  task automatic test_mode_cycle();
    goto_time(1, 2, 3);
    pulse_mode();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd1, 6'd2, 6'd3, 2'd1, 1'b1})
      $display("FAIL mode_to_set_hr: got %0d:%0d:%0d mode=%0d blink=%0d, want 1:2:3 mode=1 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
    pulse_1hz();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd1, 6'd2, 6'd3, 2'd1, 1'b0})
      $display("FAIL frozen_blink_toggle: got %0d:%0d:%0d mode=%0d blink=%0d, want 1:2:3 mode=1 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
    pulse_mode();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd1, 6'd2, 6'd3, 2'd2, 1'b1})
      $display("FAIL mode_to_set_min: got %0d:%0d:%0d mode=%0d blink=%0d, want 1:2:3 mode=2 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
    pulse_mode();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd1, 6'd2, 6'd0, 2'd0, 1'b0})
      $display("FAIL mode_to_run_sec_clr: got %0d:%0d:%0d mode=%0d blink=%0d, want 1:2:0 mode=0 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
  endtask

  task automatic test_set_wrap();
    goto_time(23, 59, 0);
    pulse_mode();
    pulse_inc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd59, 6'd0, 2'd1, 1'b1})
      $display("FAIL hr_wrap: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:59:0 mode=1 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
    pulse_mode();
    pulse_inc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd2, 1'b1})
      $display("FAIL min_wrap_no_carry: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:0:0 mode=2 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
  endtask

  task automatic test_auto_repeat();
    do_reset();
    pulse_mode();
    pulse_mode();
    btn_inc = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      clk_out = 1'b1; cyc();
      clk_out = 1'b0; cyc();
      if (i == 500) begin
        n_chk++;
        if (min !== 6'd1) $display("FAIL repeat_before_dly: got min=%0d, want 1", min);
        else n_pass++;
      end
      if (i == 501) begin
        n_chk++;
        if (min !== 6'd2) $display("FAIL repeat_first_strobe: got min=%0d, want 2", min);
        else n_pass++;
      end
    end
    btn_inc = 1'b0;
    cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd4, 6'd0, 2'd2, 1'b1})
      $display("FAIL repeat_800_edges: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:4:0 mode=2 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
  endtask

  task automatic test_collisions();
    do_reset();
    pulse_mode();
    for (int i = 0; i < 5; i++) pulse_inc();
    btn_mode = 1'b1; btn_inc = 1'b1; cyc();
    btn_mode = 1'b0; btn_inc = 1'b0; cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd5, 6'd0, 6'd0, 2'd2, 1'b1})
      $display("FAIL mode_beats_inc: got %0d:%0d:%0d mode=%0d blink=%0d, want 5:0:0 mode=2 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
    clk_1hz = 1'b1; btn_inc = 1'b1; cyc();
    clk_1hz = 1'b0; btn_inc = 1'b0; cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd5, 6'd1, 6'd0, 2'd2, 1'b0})
      $display("FAIL inc_with_1hz: got %0d:%0d:%0d mode=%0d blink=%0d, want 5:1:0 mode=2 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
    pulse_mode();
    clk_1hz = 1'b1; btn_mode = 1'b1; cyc();
    clk_1hz = 1'b0; btn_mode = 1'b0; cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd5, 6'd1, 6'd1, 2'd1, 1'b1})
      $display("FAIL tick_with_mode: got %0d:%0d:%0d mode=%0d blink=%0d, want 5:1:1 mode=1 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
  endtask

  task automatic test_held_through_reset();
    btn_mode = 1'b1; btn_inc = 1'b1; reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc(); cyc(); cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0})
      $display("FAIL held_mode_no_edge: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:0:0 mode=0 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
    btn_mode = 1'b0; cyc();
    pulse_mode();
    cyc(); cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd1, 1'b1})
      $display("FAIL held_inc_no_edge: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:0:0 mode=1 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
    btn_inc = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    goto_time(10, 20, 0);
    pulse_mode();
    pulse_mode();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd10, 6'd20, 6'd0, 2'd2, 1'b1})
      $display("FAIL pre_reset_set_min: got %0d:%0d:%0d mode=%0d blink=%0d, want 10:20:0 mode=2 blink=1", hr, min, sec, mode, blink);
    else n_pass++;
    reset = 1'b0; clk_1hz = 1'b1; btn_inc = 1'b1; btn_mode = 1'b1;
    cyc();
    n_chk++;
    if ({hr, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0})
      $display("FAIL reset_mid_op: got %0d:%0d:%0d mode=%0d blink=%0d, want 0:0:0 mode=0 blink=0", hr, min, sec, mode, blink);
    else n_pass++;
    reset = 1'b1; clk_1hz = 1'b0; btn_inc = 1'b0; btn_mode = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_mode_cycle();
    test_set_wrap();
    test_auto_repeat();
    test_collisions();
    test_held_through_reset();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
